full_adder_unit: RTL and testbench

- Parameterised, registered ripple-carry adder built from 1-bit full-adder cells.
- Computes {carry_out, sum} = a + b + carry_in.
- Default WIDTH=1 behaves as a clocked single-bit full adder.
- Used as the accumulation primitive inside the dot_product datapath. Result appears one clock after the operands are sampled.

---
 rtl/full_adder_cell.sv | 18 +
 rtl/full_adder_unit.sv | 64 ++++++
 tb/tb_full_adder_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder, the ripple element of
// full_adder_unit.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic half_sum;

    // Generate and propagate terms of a classic full adder.
    assign half_sum  = a ^ b;
    assign sum       = half_sum ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half_sum);

endmodule

// File: rtl/full_adder_unit.sv
// full_adder_unit: registered ripple-carry adder,
// {carry_out, sum} = a + b + carry_in, with one cycle of latency.
//
// Valid semantics: in_valid qualifies a/b/carry_in at a rising clk edge.
// out_valid is high during the cycle after such an edge, and sum/carry_out
// then hold that result. When in_valid is low, the operands are ignored and
// the previous result is held, but out_valid drops. The block has no
// backpressure, so it accepts a new operand set on every clock.
module full_adder_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             out_valid
);

    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_d;
    logic             carry_out_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;
    logic             out_valid_q;

    assign carry_chain[0] = carry_in;

    // The carry ripples from bit 0 up to the MSB through one cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a         (a[i]),
            .b         (b[i]),
            .carry_in  (carry_chain[i]),
            .sum       (sum_d[i]),
            .carry_out (carry_chain[i+1])
        );
    end

    assign carry_out_d = carry_chain[WIDTH];

    // Result register: load on valid, hold otherwise. Reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q       <= sum_d;
                carry_out_q <= carry_out_d;
            end
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_unit.sv
// tb_full_adder_unit: directed and random checks of a 1-bit and an 8-bit
// full_adder_unit sharing one clock and reset.
module tb_full_adder_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       in_valid1 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
    logic       sum1, cout1, vld1;

    logic       in_valid8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ci8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8, vld8;

    full_adder_unit #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .carry_in  (ci1),
        .sum       (sum1),
        .carry_out (cout1),
        .out_valid (vld1)
    );

    full_adder_unit #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .carry_in  (ci8),
        .sum       (sum8),
        .carry_out (cout8),
        .out_valid (vld8)
    );

    // ---------------- scoreboard ----------------
    logic [1:0] exp1_q[$];
    logic [8:0] exp8_q[$];
    logic [1:0] hold1 = '0;   // {carry_out, sum} the 1-bit DUT should show
    logic [8:0] hold8 = '0;   // {carry_out, sum} the 8-bit DUT should show
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock of the 1-bit DUT; the 8-bit DUT idles.
    task automatic step1(input string tag, input logic rst, input logic v,
                         input logic a, input logic b, input logic ci);
        logic exp_vld;
        rst_n = rst; in_valid1 = v; a1 = a; b1 = b; ci1 = ci;
        in_valid8 = 1'b0; a8 = 'x; b8 = 'x; ci8 = 1'bx;
        if (!rst) begin
            exp_vld = 1'b0; hold1 = '0; hold8 = '0;
        end else if (v) begin
            exp1_q.push_back({1'b0, a} + {1'b0, b} + {1'b0, ci});
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(vld1), 64'(exp_vld));
        if (exp_vld) hold1 = exp1_q.pop_front();
        check({tag, "_result"}, 64'({cout1, sum1}), 64'(hold1));
    endtask

    // One clock of the 8-bit DUT; the 1-bit DUT idles.
    task automatic step8(input string tag, input logic rst, input logic v,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic exp_vld;
        rst_n = rst; in_valid8 = v; a8 = a; b8 = b; ci8 = ci;
        in_valid1 = 1'b0; a1 = 1'bx; b1 = 1'bx; ci1 = 1'bx;
        if (!rst) begin
            exp_vld = 1'b0; hold1 = '0; hold8 = '0;
        end else if (v) begin
            exp8_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(vld8), 64'(exp_vld));
        if (exp_vld) hold8 = exp8_q.pop_front();
        check({tag, "_result"}, 64'({cout8, sum8}), 64'(hold8));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] combo;
        logic [1:0] table1 [8];
        table1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset held for two cycles while valid operands 1,1,1 are offered.
        step1("rst0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst0_w8", 64'({vld8, cout8, sum8}), 64'd0);
        step1("rst1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        // First operand after release gives 11 one cycle later.
        step1("rel", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rel_const", 64'({cout1, sum1}), 64'd3);

        // Exhaustive 1-bit truth table against a fixed table.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            step1("exh", 1'b1, 1'b1, combo[2], combo[1], combo[0]);
            check("exh_table", 64'({cout1, sum1}), 64'(table1[i]));
        end

        // Produce 01, then hold for three cycles with toggling or X operands.
        step1("pre_hold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step1("hold0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step1("hold1", 1'b1, 1'b0, 1'bx, 1'bx, 1'bx);
        step1("hold2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("hold_const", 64'({vld1, cout1, sum1}), 64'b001);

        // 8-bit boundaries, also checked against literal results.
        step8("b_ff01", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
        check("b_ff01_const", 64'({cout8, sum8}), 64'h100);
        step8("b_ffff", 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        check("b_ffff_const", 64'({cout8, sum8}), 64'h1FF);
        step8("b_5a25", 1'b1, 1'b1, 8'h5A, 8'h25, 1'b1);
        check("b_5a25_const", 64'({cout8, sum8}), 64'h080);
        step8("b_0001", 1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
        check("b_0001_const", 64'({cout8, sum8}), 64'h001);

        // Back-to-back random stream.
        for (int i = 0; i < 100; i++)
            step8("rnd", 1'b1, 1'b1, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // Reset for one cycle in the middle of a stream, then resume.
        for (int i = 0; i < 5; i++)
            step8("mid_pre", 1'b1, 1'b1, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        step8("mid_rst", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        check("mid_rst_const", 64'({vld8, cout8, sum8}), 64'd0);
        for (int i = 0; i < 10; i++)
            step8("mid_post", 1'b1, 1'b1, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // Every pushed expectation must have been consumed.
        check("q1_empty", 64'(exp1_q.size()), 64'd0);
        check("q8_empty", 64'(exp8_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=stalled expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
